// File: rtl/vhls_target_core_pkg.sv
// Shared types for the vhls_target_core streaming kernel.
// Holds the default word width and the kernel FSM encoding.
package vhls_target_core_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    READ    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/vhls_target_core_stream.sv
// HLS_stream: synchronous FIFO with a registered head word.
// read_ready = non-empty, write_ready = not full.
module HLS_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] in_data_bus,
  input  logic                  in_last_bus,
  input  logic                  read_valid,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] data_bus,
  output logic                  last_bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW:0]         count;
  logic                push;
  logic                pop;

  assign write_ready = (count != (AW+1)'(DEPTH));
  assign read_ready  = (count != '0);
  assign push        = write_valid && write_ready;
  assign pop         = read_valid && read_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_last_bus, in_data_bus};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_bus <= '0;
      last_bus <= 1'b0;
    end else begin
      if (push) begin
        wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
        {last_bus, data_bus} <= mem[rptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vhls_target_core.sv
// Streaming kernel: pop a word, double it, push it with its last flag.
// Raises a sticky done flag once the last-flagged word has been pushed.
module vhls_target_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arg_0_read_ready,
  output logic                  arg_0_read_valid,
  input  logic [DATA_WIDTH-1:0] arg_0_data_bus,
  input  logic                  arg_0_last_bus,
  input  logic                  arg_0_write_ready,
  input  logic                  arg_1_write_ready,
  output logic                  arg_1_write_valid,
  output logic [DATA_WIDTH-1:0] arg_1_in_data_bus,
  output logic                  arg_1_in_last_bus,
  input  logic                  arg_1_read_ready,
  input  logic [DATA_WIDTH-1:0] arg_1_data_bus,
  input  logic                  arg_1_last_bus,
  output logic                  valid
);

  import vhls_target_core_pkg::*;

  state_t                state;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  unused_in;

  assign unused_in = ^{arg_0_write_ready, arg_1_read_ready,
                       arg_1_data_bus, arg_1_last_bus};

  // Pop is combinational so the head word lands during CAPTURE.
  assign arg_0_read_valid  = rst && (state == READ) && arg_0_read_ready;
  assign arg_1_in_data_bus = data;
  assign arg_1_in_last_bus = last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= READ;
      data              <= '0;
      last              <= 1'b0;
      arg_1_write_valid <= 1'b0;
      valid             <= 1'b0;
    end else begin
      arg_1_write_valid <= 1'b0;
      unique case (state)
        READ: begin
          if (arg_0_read_ready) state <= CAPTURE;
        end
        CAPTURE: begin
          data  <= {arg_0_data_bus[DATA_WIDTH-2:0], 1'b0};
          last  <= arg_0_last_bus;
          state <= WRITE;
        end
        WRITE: begin
          if (arg_1_write_ready) begin
            arg_1_write_valid <= 1'b1;
            state             <= last ? DONE : READ;
          end
        end
        DONE: begin
          valid <= 1'b1;
        end
        default: state <= READ;
      endcase
    end
  end

endmodule

// File: tb/tb_vhls_target_core.sv
// Bench for vhls_target_core between two HLS_stream FIFOs.
// Random packets are checked against a queue model of doubled words.
module tb_vhls_target_core;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_wv = 1'b0;
  logic [W-1:0] in_d = '0;
  logic         in_l = 1'b0;
  logic         in_wr, in_rr, rv, in_lb;
  logic [W-1:0] in_db;
  logic         wv, wl, out_wr, out_rr, out_lb, done;
  logic [W-1:0] wd, out_db;
  logic         out_rv = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_d[$];
  logic         exp_l[$];
  bit           mdl_done = 1'b0;

  int cyc = 0;
  int pushes = 0;
  int pops = 0;
  int bad_push = 0;
  int bad_pop = 0;
  int b2b = 0;
  int pop_cyc = -100;
  int push_cyc = -100;

  always #5 clk = ~clk;

  HLS_stream #(.DATA_WIDTH(W), .DEPTH(16)) u_in (
    .clk(clk), .rst(rst),
    .write_valid(in_wv), .write_ready(in_wr),
    .in_data_bus(in_d), .in_last_bus(in_l),
    .read_valid(rv), .read_ready(in_rr),
    .data_bus(in_db), .last_bus(in_lb)
  );

  vhls_target_core #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .arg_0_read_ready(in_rr), .arg_0_read_valid(rv),
    .arg_0_data_bus(in_db), .arg_0_last_bus(in_lb),
    .arg_0_write_ready(in_wr),
    .arg_1_write_ready(out_wr), .arg_1_write_valid(wv),
    .arg_1_in_data_bus(wd), .arg_1_in_last_bus(wl),
    .arg_1_read_ready(out_rr), .arg_1_data_bus(out_db),
    .arg_1_last_bus(out_lb),
    .valid(done)
  );

  HLS_stream #(.DATA_WIDTH(W), .DEPTH(16)) u_out (
    .clk(clk), .rst(rst),
    .write_valid(wv), .write_ready(out_wr),
    .in_data_bus(wd), .in_last_bus(wl),
    .read_valid(out_rv), .read_ready(out_rr),
    .data_bus(out_db), .last_bus(out_lb)
  );

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      pop_cyc = -100;
    end else begin
      if (wv && !out_wr) bad_push++;
      if (rv && !in_rr) bad_pop++;
      if (rv) begin
        if (cyc - pop_cyc < 3) b2b++;
        pop_cyc = cyc;
        pops++;
      end
      if (wv) begin
        pushes++;
        push_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_wv = 1'b0;
    out_rv = 1'b0;
    tick(2);
    exp_d.delete();
    exp_l.delete();
    mdl_done = 1'b0;
    rst = 1'b1;
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    while (!in_wr && n < 300) begin
      tick();
      n++;
    end
    in_wv = 1'b1;
    in_d = d;
    in_l = l;
    tick();
    in_wv = 1'b0;
    if (!mdl_done) begin
      exp_d.push_back(W'((int'(d) * 2) % 65536));
      exp_l.push_back(l);
      if (l) mdl_done = 1'b1;
    end
  endtask

  task automatic pop_check(input string name);
    int n;
    logic [W-1:0] ed;
    logic el;
    n = 0;
    while (!out_rr && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (!out_rr) begin
      errors++;
      $display("FAIL %s: output FIFO stayed empty, read_ready=%0b want 1",
               name, out_rr);
      return;
    end
    out_rv = 1'b1;
    tick();
    out_rv = 1'b0;
    if (exp_d.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected word %0d/%0b, model queue empty",
               name, out_db, out_lb);
      return;
    end
    ed = exp_d.pop_front();
    el = exp_l.pop_front();
    if ({out_lb, out_db} !== {el, ed}) begin
      errors++;
      $display("FAIL %s: got %0d/%0b want %0d/%0b",
               name, out_db, out_lb, ed, el);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: valid=%0b want 1 within %0d cycles",
               name, done, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks++;
    if ({rv, wv, done, wl, wd} !== '0) begin
      errors++;
      $display("FAIL reset: rv=%0b wv=%0b valid=%0b last=%0b data=%0h want all 0",
               rv, wv, done, wl, wd);
    end
    rst = 1'b1;
    exp_d.delete();
    exp_l.delete();
    mdl_done = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    int base;
    do_reset();
    base = pushes;
    push_word(16'd28, 1'b0);
    checks++;
    if (out_rr !== 1'b0) begin
      errors++;
      $display("FAIL nominal_early: out read_ready=%0b want 0", out_rr);
    end
    push_word(16'd10, 1'b0);
    push_word(16'd7, 1'b0);
    push_word(16'd3, 1'b1);
    n = 0;
    while (!out_rr && n < 25) begin
      tick();
      n++;
    end
    checks++;
    if (out_rr !== 1'b1) begin
      errors++;
      $display("FAIL nominal_first: out read_ready=%0b want 1", out_rr);
    end
    wait_done("nominal_done", 700);
    checks++;
    if (pushes - base !== 4) begin
      errors++;
      $display("FAIL nominal_count: pushes=%0d want 4", pushes - base);
    end
    for (int i = 0; i < 4; i++) begin
      pop_check("nominal_data");
      tick();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push_word(16'h8001, 1'b1);
    wait_done("overflow_done", 50);
    checks++;
    if (push_cyc - pop_cyc !== 3) begin
      errors++;
      $display("FAIL latency: pop-to-push=%0d want 3", push_cyc - pop_cyc);
    end
    pop_check("overflow_data");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push_word(W'($urandom), i == 19);
    end
    tick(150);
    checks++;
    if ({out_wr, done} !== 2'b00) begin
      errors++;
      $display("FAIL bp_full: write_ready=%0b valid=%0b want 0/0",
               out_wr, done);
    end
    for (int i = 0; i < 20; i++) begin
      pop_check("bp_data");
      tick($urandom_range(0, 4));
    end
    wait_done("bp_done", 20);
    checks++;
    if (exp_d.size() !== 0 || out_rr !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: left=%0d out read_ready=%0b want 0/0",
               exp_d.size(), out_rr);
    end
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 4; p++) begin
      do_reset();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        push_word(W'($urandom), i == len - 1);
        tick($urandom_range(0, 5));
      end
      for (int i = 0; i < len; i++) begin
        pop_check("random_data");
        tick($urandom_range(0, 6));
      end
      wait_done("random_done", 20);
    end
  endtask

  task automatic test_empty();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (rv || done) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL empty: %0d cycles with pop or valid, want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    int n;
    do_reset();
    base = pushes;
    for (int i = 0; i < 4; i++) push_word(W'($urandom), i == 3);
    n = 0;
    while (pushes - base < 2 && n < 100) begin
      tick();
      n++;
    end
    do_reset();
    tick();
    checks++;
    if ({done, rv, out_rr} !== 3'b000) begin
      errors++;
      $display("FAIL midrst: valid=%0b rv=%0b out_rr=%0b want 0/0/0",
               done, rv, out_rr);
    end
    push_word(16'd5, 1'b1);
    wait_done("midrst_done", 50);
    pop_check("midrst_data");
  endtask

  task automatic test_post_done();
    int base;
    base = pops;
    for (int i = 0; i < 3; i++) push_word(W'($urandom), 1'b0);
    tick(40);
    checks++;
    if (in_rr !== 1'b1 || pops !== base || done !== 1'b1) begin
      errors++;
      $display("FAIL post_done: in_rr=%0b pops=%0d valid=%0b want 1/0/1",
               in_rr, pops - base, done);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (bad_push !== 0 || bad_pop !== 0 || b2b !== 0) begin
      errors++;
      $display("FAIL protocol: full_push=%0d empty_pop=%0d close_pop=%0d want 0",
               bad_push, bad_pop, b2b);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_backpressure();
    test_random();
    test_empty();
    test_mid_reset();
    test_post_done();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
